// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_buffer
// Description : Captures retirement events from register-file and data-memory
//               probes. Each event becomes one 72-bit record in a
//               first-word-fall-through FIFO. Counts retired events and
//               records dropped on overflow. A captured halt freezes capture
//               until reset.
//               Optional feature: define TRACE_CYCLE_STAMP_EN to stamp each
//               record with a free-running 16-bit cycle counter. Without it
//               the stamp field is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        reg_we,
    input  logic [3:0]  reg_dst,
    input  logic [15:0] reg_data,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [71:0] out_data,
    output logic [31:0] inst_count,
    output logic [15:0] drop_count,
    output logic        halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

    // Record storage and control state
    logic [71:0]   r_mem_q [DEPTH];
    logic [AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0] r_cnt_q,    w_cnt_d;
    logic [31:0]   r_inst_q,   w_inst_d;
    logic [15:0]   r_drop_q,   w_drop_d;
    logic          r_halted_q, w_halted_d;

    logic          w_event;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_store;
    logic          w_load;
    logic [15:0]   w_mdata;
    logic [15:0]   w_stamp;
    logic [71:0]   w_rec;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] r_cyc_q, w_cyc_d;

    // Free-running cycle counter; wraps naturally at 0xFFFF
    always_comb begin
        w_cyc_d = r_cyc_q + 16'd1;
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_q <= '0;
        end else begin
            r_cyc_q <= w_cyc_d;
        end
    end

    // Stamp is the count before this edge's increment
    assign w_stamp = r_cyc_q;
`else
    assign w_stamp = '0;
`endif

    // Event qualification and record assembly
    always_comb begin
        w_empty = (r_cnt_q == '0);
        w_full  = (r_cnt_q == c_full_cnt);
        w_event = cap_en & ~r_halted_q & (reg_we | mem_en | halt);
        w_pop   = ~w_empty & out_ready;
        // A full FIFO still accepts when the head leaves on the same edge
        w_push  = w_event & (~w_full | w_pop);
        w_store = mem_en & mem_wr;
        w_load  = mem_en & ~mem_wr;
        w_mdata = w_store ? mem_wdata : (w_load ? mem_rdata : 16'h0000);
        w_rec   = {halt, w_store, w_load, reg_we,
                   reg_we ? reg_dst  : 4'h0,
                   reg_we ? reg_data : 16'h0000,
                   mem_en ? mem_addr : 16'h0000,
                   w_mdata,
                   w_stamp};
    end

    // Next-state for pointers, occupancy, counters and halt flag
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_cnt_d    = r_cnt_q;
        w_inst_d   = r_inst_q;
        w_drop_d   = r_drop_q;
        w_halted_d = r_halted_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_d = r_cnt_q + CW'(1);
            2'b01:   w_cnt_d = r_cnt_q - CW'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
        if (w_event) begin
            w_inst_d = r_inst_q + 32'd1;
        end
        if (w_event && !w_push && (r_drop_q != 16'hFFFF)) begin
            w_drop_d = r_drop_q + 16'd1;
        end
        if (w_event && halt) begin
            w_halted_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_cnt_q    <= '0;
            r_inst_q   <= '0;
            r_drop_q   <= '0;
            r_halted_q <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_cnt_q    <= w_cnt_d;
            r_inst_q   <= w_inst_d;
            r_drop_q   <= w_drop_d;
            r_halted_q <= w_halted_d;
        end
    end

    // Record storage; contents need no reset since out_data is gated by occupancy
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_wr_ptr_q] <= w_rec;
        end
    end

    assign out_valid  = ~w_empty;
    assign out_data   = w_empty ? 72'h0 : r_mem_q[r_rd_ptr_q];
    assign inst_count = r_inst_q;
    assign drop_count = r_drop_q;
    assign halted     = r_halted_q;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_retire_trace_buffer
// Description : Directed self-checking bench for retire_trace_buffer
//               (DEPTH = 8). Honours TRACE_CYCLE_STAMP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

    logic        clk;
    logic        rst;
    logic        cap_en;
    logic        reg_we;
    logic [3:0]  reg_dst;
    logic [15:0] reg_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        halt;
    logic        out_ready;
    logic        out_valid;
    logic [71:0] out_data;
    logic [31:0] inst_count;
    logic [15:0] drop_count;
    logic        halted;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [71:0] expq[$];
    logic [31:0] inst_base;

    retire_trace_buffer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .reg_data   (reg_data),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .halt       (halt),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .inst_count (inst_count),
        .drop_count (drop_count),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns later. cyc models the
    // cycle counter: cleared by reset edges, +1 on every other edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    endtask

    function automatic logic [15:0] stamp_now();
`ifdef TRACE_CYCLE_STAMP_EN
        return cyc[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic idle();
        reg_we    = 1'b0; reg_dst   = 4'h0; reg_data  = 16'h0;
        mem_en    = 1'b0; mem_wr    = 1'b0; mem_addr  = 16'h0;
        mem_wdata = 16'h0; mem_rdata = 16'h0; halt     = 1'b0;
    endtask

    task automatic reg_event(input logic [3:0] d, input logic [15:0] v);
        idle();
        reg_we = 1'b1; reg_dst = d; reg_data = v;
        mem_addr = 16'hDEAD;
    endtask

    initial begin
        cap_en = 1'b1; out_ready = 1'b0; idle();

        // Reset with a coincident event: capture must be suppressed
        rst = 1'b1;
        reg_we = 1'b1; reg_dst = 4'h7; reg_data = 16'h7777;
        tick();
        tick();
        rst = 1'b0;
        check_vec("rst_valid", 72'(out_valid), 72'h0);
        check_vec("rst_data",  out_data, 72'h0);
        check_vec("rst_inst",  72'(inst_count), 72'h0);
        check_vec("rst_drop",  72'(drop_count), 72'h0);
        check_vec("rst_halt",  72'(halted), 72'h0);

        // Four edges with probes active but capture disabled
        cap_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_vec("capdis_inst", 72'(inst_count), 72'h0);
        cap_en = 1'b1;

        // Store at the fifth edge after release; unflagged reg fields zeroed
        idle();
        reg_dst = 4'h5; reg_data = 16'hAAAA;
        mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0010;
        mem_wdata = 16'hBEEF; mem_rdata = 16'h5555;
        out_ready = 1'b1;
`ifdef TRACE_CYCLE_STAMP_EN
        check_vec("stamp_model", 72'(stamp_now()), 72'd4);
`endif
        expq.push_back({4'b0100, 4'h0, 16'h0, 16'h0010, 16'hBEEF, stamp_now()});
        tick();
        idle();
        check_vec("st_valid", 72'(out_valid), 72'h1);
        check_vec("st_rec",   out_data, expq.pop_front());
        check_vec("st_inst",  72'(inst_count), 72'd1);
        tick();
        check_vec("st_popped", 72'(out_valid), 72'h0);
        check_vec("st_zero",   out_data, 72'h0);

        // Load with register write-back
        reg_we = 1'b1; reg_dst = 4'h3; reg_data = 16'h1234;
        mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0020;
        mem_wdata = 16'hFFFF; mem_rdata = 16'h1234;
        out_ready = 1'b0;
        expq.push_back({4'b0011, 4'h3, 16'h1234, 16'h0020, 16'h1234, stamp_now()});
        tick();
        idle();
        check_vec("ld_rec", out_data, expq[0]);
        tick();
        tick();
        check_vec("ld_hold", out_data, expq[0]);
        out_ready = 1'b1;
        tick();
        void'(expq.pop_front());
        check_vec("ld_popped", 72'(out_valid), 72'h0);

        // Overflow: ten events, consumer stalled
        out_ready = 1'b0;
        inst_base = inst_count;
        for (int i = 0; i < 10; i++) begin
            reg_event(4'(i), 16'h0100 + 16'(i));
            if (i < 8) expq.push_back({4'b0001, 4'(i), 16'h0100 + 16'(i), 16'h0, 16'h0, stamp_now()});
            tick();
        end
        idle();
        check_vec("ov_drop", 72'(drop_count), 72'd2);
        check_vec("ov_inst", 72'(inst_count - inst_base), 72'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_vec("ov_valid", 72'(out_valid), 72'h1);
            check_vec("ov_rec", out_data, expq.pop_front());
            tick();
        end
        check_vec("ov_empty", 72'(out_valid), 72'h0);

        // Reset mid-drain discards buffered records
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reg_event(4'hE, 16'hE000 + 16'(i));
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rm_valid", 72'(out_valid), 72'h0);
        check_vec("rm_drop",  72'(drop_count), 72'h0);
        check_vec("rm_inst",  72'(inst_count), 72'h0);

        // Full FIFO: ninth event coincides with a pop
        for (int i = 0; i < 9; i++) begin
            reg_event(4'(i), 16'h0200 + 16'(i));
            expq.push_back({4'b0001, 4'(i), 16'h0200 + 16'(i), 16'h0, 16'h0, stamp_now()});
            if (i == 8) begin
                out_ready = 1'b1;
                check_vec("pp_head", out_data, expq.pop_front());
            end
            tick();
        end
        idle();
        check_vec("pp_drop", 72'(drop_count), 72'h0);
        check_vec("pp_inst", 72'(inst_count), 72'd9);
        for (int i = 0; i < 8; i++) begin
            check_vec("pp_rec", out_data, expq.pop_front());
            tick();
        end
        check_vec("pp_empty", 72'(out_valid), 72'h0);

        // Halt freezes capture; FIFO still drains
        out_ready = 1'b0;
        inst_base = inst_count;
        halt = 1'b1;
        expq.push_back({4'b1000, 4'h0, 16'h0, 16'h0, 16'h0, stamp_now()});
        tick();
        for (int i = 0; i < 3; i++) begin
            reg_event(4'h9, 16'h9999);
            tick();
        end
        idle();
        check_vec("h_halted", 72'(halted), 72'h1);
        check_vec("h_inst",   72'(inst_count - inst_base), 72'd1);
        check_vec("h_rec",    out_data, expq.pop_front());
        out_ready = 1'b1;
        tick();
        check_vec("h_drained", 72'(out_valid), 72'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("h_rst", 72'(halted), 72'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entry count, power of two, minimum 2.
REQ-002 The block SHALL have the following ports, one per line:
  clk  input  1  sole clock; all state updates on rising edge.
  rst  input  1  synchronous reset, active-high.
  cap_en  input  1  capture enable; low = ignore all probe inputs.
  reg_we  input  1  register-file write this cycle.
  reg_dst  input  4  register written.
  reg_data  input  16  data written to register.
  mem_en  input  1  data-memory access this cycle.
  mem_wr  input  1  1 = store, 0 = load (valid when mem_en).
  mem_addr  input  16  data-memory address.
  mem_wdata  input  16  store data.
  mem_rdata  input  16  load data.
  halt  input  1  halt instruction retiring.
  out_ready  input  1  consumer accepts head record.
  out_valid  output  1  head record available.
  out_data  output  72  head record.
  inst_count  output  32  retired-event count.
  drop_count  output  16  records lost to a full FIFO.
  halted  output  1  halt captured; capture frozen.

Function
REQ-003 An event cycle SHALL be a rising edge with cap_en=1, halted=0, and (reg_we | mem_en | halt)=1.
REQ-004 Each event cycle SHALL form exactly one record: [71:68] flags {halt, store=mem_en&mem_wr, load=mem_en&~mem_wr, reg=reg_we}; [67:64] reg_dst; [63:48] reg_data; [47:32] mem_addr; [31:16] mem_wdata if store, else mem_rdata if load, else 0; [15:0] cycle stamp.
REQ-005 Fields whose flag is 0 SHALL be zero in the record: reg_dst and reg_data when reg=0; mem_addr when mem_en=0.
REQ-006 The FIFO SHALL be first-word-fall-through: out_valid = not empty; out_data = head record; out_data SHALL be zero when empty.
REQ-007 A record captured at edge N SHALL appear on out_valid/out_data after edge N when the FIFO was empty (one-cycle latency).
REQ-008 A pop SHALL occur on an edge with out_valid & out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 Push while full and no pop SHALL discard the record and increment drop_count, which saturates at 0xFFFF.
REQ-010 Push and pop on the same edge while full SHALL accept the push; occupancy remains DEPTH; drop_count unchanged.
REQ-011 Push and pop on the same edge while empty SHALL not occur, because out_valid=0 when empty.
REQ-012 inst_count SHALL increment by 1 on every event cycle, including dropped ones, and wrap modulo 2^32.
REQ-013 A captured halt SHALL set halted=1 at that edge; later events are ignored until rst; the FIFO keeps draining.
REQ-014 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a DEPTH+1-state counter or an extra pointer bit.

Reset
REQ-015 While rst=1 at an edge, the block SHALL clear pointers, occupancy, inst_count, drop_count, halted and cycle stamp, and ignore probe inputs.
REQ-016 After reset: out_valid=0, out_data=0, inst_count=0, drop_count=0, halted=0.
REQ-017 Reset mid-drain SHALL discard all buffered records.
REQ-018 A reset coinciding with an event SHALL suppress that capture.

Configuration
REQ-019 With macro TRACE_CYCLE_STAMP_EN defined:
  - a 16-bit counter SHALL increment every non-reset edge, wrapping at 0xFFFF.
  - the record stamp SHALL be the counter value before that edge's increment.
REQ-020 With TRACE_CYCLE_STAMP_EN undefined:
  - no counter SHALL be instantiated.
  - stamp bits [15:0] SHALL be zero.

Verification
REQ-021 Store event: reg_we=0, mem_en=1, mem_wr=1, addr 0x0010, wdata 0xBEEF, out_ready=1 -> next cycle out_valid=1, flags 0100, [47:32]=0x0010, [31:16]=0xBEEF; inst_count=1.
REQ-022 Load event: reg_we=1, dst 3, data 0x1234, mem_en=1, mem_wr=0, rdata 0x1234 -> one record with flags 0011, [67:64]=3, [31:16]=0x1234.
REQ-023 Overflow: out_ready=0, 10 consecutive events, DEPTH=8 -> 8 records retained in order; drop_count=2; inst_count=10.
REQ-024 Simultaneous push/pop when full: out_ready=1 on the 9th event -> drop_count=0; the 9th record is delivered in order.
REQ-025 Halt: halt=1 then reg_we=1 for 3 cycles -> halted=1; only the halt record is added; inst_count increments once.
REQ-026 Stamp (macro defined): rst released, first event at the 5th edge after release -> stamp=4; stamp=0 with the macro undefined.
